// File: rtl/bf_loop_core_pkg.sv
// Shared opcode encodings and FSM state type for the bf_loop_core Brainfuck core.
package bf_loop_core_pkg;

  localparam logic [7:0] OP_INC   = 8'h2B;
  localparam logic [7:0] OP_DEC   = 8'h2D;
  localparam logic [7:0] OP_RIGHT = 8'h3E;
  localparam logic [7:0] OP_LEFT  = 8'h3C;
  localparam logic [7:0] OP_OUT   = 8'h2E;
  localparam logic [7:0] OP_IN    = 8'h2C;
  localparam logic [7:0] OP_LOOP  = 8'h5B;
  localparam logic [7:0] OP_END   = 8'h5D;
  localparam logic [7:0] OP_HALT  = 8'h00;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_OUT,
    ST_IN,
    ST_HALT,
    ST_ERROR
  } bf_state_e;

endpackage

// File: rtl/bf_loop_stack.sv
// LIFO of loop-start addresses; push/pop ignored when full/empty, the core checks first.
module bf_loop_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    sp_q, sp_d;

  assign empty = (sp_q == '0);
  assign full  = (sp_q == PW'(DEPTH));
  assign top   = mem_q[AW'(sp_q - PW'(1))];

  always_comb begin
    sp_d = sp_q;
    if (push && !full)       sp_d = sp_q + PW'(1);
    else if (pop && !empty)  sp_d = sp_q - PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) sp_q <= '0;
    else       sp_q <= sp_d;
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[AW'(sp_q)] <= push_data;
  end

endmodule

// File: rtl/bf_loop_core.sv
// Multicycle Brainfuck core with hardware loop stack and valid/ready byte I/O.
// Define BF_RETIRE_COUNT_EN to add the 32-bit 'retired' completed-op counter port.
module bf_loop_core
  import bf_loop_core_pkg::*;
#(
  parameter int IA_WIDTH    = 12,
  parameter int DA_WIDTH    = 12,
  parameter int DD_WIDTH    = 8,
  parameter int STACK_DEPTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ice,
  output logic [IA_WIDTH-1:0] ia,
  input  logic [7:0]          id,
  output logic                drce,
  output logic [DA_WIDTH-1:0] dra,
  input  logic [DD_WIDTH-1:0] drd,
  output logic                dwce,
  output logic [DA_WIDTH-1:0] dwa,
  output logic [DD_WIDTH-1:0] dwq,
  input  logic                in_valid,
  input  logic [DD_WIDTH-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [DD_WIDTH-1:0] out_data,
  input  logic                out_ready,
  output logic                halted,
  output logic                error
`ifdef BF_RETIRE_COUNT_EN
  ,
  output logic [31:0]         retired
`endif
);

  bf_state_e           state_q, state_d;
  logic [IA_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic [DA_WIDTH-1:0] dp_q, dp_d;
  logic                skip_q, skip_d;
  logic [IA_WIDTH-1:0] depth_q, depth_d;
  logic [7:0]          op_q, op_d;
  logic [DD_WIDTH-1:0] out_data_q, out_data_d;

  logic                ice_c, drce_c, dwce_c, in_ready_c, out_valid_c;
  logic [DD_WIDTH-1:0] dwq_c, out_data_c;
  logic                push, pop, retire;
  logic [IA_WIDTH-1:0] top;
  logic                empty, full;
  logic                run;

  bf_loop_stack #(.WIDTH(IA_WIDTH), .DEPTH(STACK_DEPTH)) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_q),
    .top       (top),
    .empty     (empty),
    .full      (full)
  );

  assign pc_inc = pc_q + IA_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    dp_d        = dp_q;
    skip_d      = skip_q;
    depth_d     = depth_q;
    op_d        = op_q;
    out_data_d  = out_data_q;
    ice_c       = 1'b0;
    drce_c      = 1'b0;
    dwce_c      = 1'b0;
    dwq_c       = '0;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    out_data_c  = '0;
    push        = 1'b0;
    pop         = 1'b0;
    retire      = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ice_c   = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        op_d    = id;
        state_d = ST_FETCH;
        if (skip_q) begin
          // Skipping a zero-trip loop body: only bracket nesting is tracked.
          if (id == OP_HALT) begin
            state_d = ST_ERROR;
          end else begin
            pc_d   = pc_inc;
            retire = 1'b1;
            if (id == OP_LOOP) begin
              depth_d = depth_q + IA_WIDTH'(1);
            end else if (id == OP_END) begin
              depth_d = depth_q - IA_WIDTH'(1);
              if (depth_q == IA_WIDTH'(1)) skip_d = 1'b0;
            end
          end
        end else begin
          case (id)
            OP_HALT:  state_d = ST_HALT;
            OP_RIGHT: begin dp_d = dp_q + DA_WIDTH'(1); pc_d = pc_inc; retire = 1'b1; end
            OP_LEFT:  begin dp_d = dp_q - DA_WIDTH'(1); pc_d = pc_inc; retire = 1'b1; end
            OP_IN:    state_d = ST_IN;
            OP_INC, OP_DEC, OP_OUT, OP_LOOP, OP_END: begin
              drce_c  = 1'b1;
              state_d = ST_EXEC;
            end
            default:  begin pc_d = pc_inc; retire = 1'b1; end
          endcase
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (op_q)
          OP_INC, OP_DEC: begin
            dwce_c = 1'b1;
            dwq_c  = (op_q == OP_INC) ? drd + DD_WIDTH'(1) : drd - DD_WIDTH'(1);
            pc_d   = pc_inc;
            retire = 1'b1;
          end
          OP_OUT: begin
            // Offer the byte straight from DRAM; hold a copy in case the sink stalls.
            out_valid_c = 1'b1;
            out_data_c  = drd;
            out_data_d  = drd;
            if (out_ready) begin
              pc_d   = pc_inc;
              retire = 1'b1;
            end else begin
              state_d = ST_OUT;
            end
          end
          OP_LOOP: begin
            if (drd != '0) begin
              if (full) begin
                state_d = ST_ERROR;
              end else begin
                push   = 1'b1;
                pc_d   = pc_inc;
                retire = 1'b1;
              end
            end else begin
              pc_d    = pc_inc;
              skip_d  = 1'b1;
              depth_d = IA_WIDTH'(1);
              retire  = 1'b1;
            end
          end
          OP_END: begin
            if (empty) begin
              state_d = ST_ERROR;
            end else if (drd != '0) begin
              pc_d   = top + IA_WIDTH'(1);
              retire = 1'b1;
            end else begin
              pop    = 1'b1;
              pc_d   = pc_inc;
              retire = 1'b1;
            end
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_OUT: begin
        out_valid_c = 1'b1;
        out_data_c  = out_data_q;
        if (out_ready) begin
          pc_d    = pc_inc;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_IN: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          dwce_c  = 1'b1;
          dwq_c   = in_data;
          pc_d    = pc_inc;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      dp_q    <= '0;
      skip_q  <= 1'b0;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      dp_q    <= dp_d;
      skip_q  <= skip_d;
      depth_q <= depth_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q       <= op_d;
    out_data_q <= out_data_d;
  end

  // Every output is forced low while reset is asserted, so nothing escapes a reset cycle.
  assign run       = ~reset;
  assign ice       = run & ice_c;
  assign ia        = run ? pc_q : '0;
  assign drce      = run & drce_c;
  assign dra       = run ? dp_q : '0;
  assign dwce      = run & dwce_c;
  assign dwa       = run ? dp_q : '0;
  assign dwq       = run ? dwq_c : '0;
  assign in_ready  = run & in_ready_c;
  assign out_valid = run & out_valid_c;
  assign out_data  = run ? out_data_c : '0;
  assign halted    = run & ((state_q == ST_HALT) || (state_q == ST_ERROR));
  assign error     = run & (state_q == ST_ERROR);

`ifdef BF_RETIRE_COUNT_EN
  logic [31:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (retire) retired_d = retired_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign retired = run ? retired_q : '0;
`endif

endmodule

// File: tb/tb_bf_loop_core.sv
// Scoreboard bench for bf_loop_core: small programs in an IROM model, DRAM model, byte streams.
module tb_bf_loop_core;
  import bf_loop_core_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ice, drce, dwce, in_ready, out_valid, halted, error;
  logic [11:0] ia, dra, dwa;
  logic [7:0]  id, drd, dwq, in_data, out_data;
  logic        in_valid, out_ready;
`ifdef BF_RETIRE_COUNT_EN
  logic [31:0] retired;
`endif

  always #5 clk = ~clk;

  bf_loop_core dut (
    .clk       (clk),
    .reset     (reset),
    .ice       (ice),
    .ia        (ia),
    .id        (id),
    .drce      (drce),
    .dra       (dra),
    .drd       (drd),
    .dwce      (dwce),
    .dwa       (dwa),
    .dwq       (dwq),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .halted    (halted),
    .error     (error)
`ifdef BF_RETIRE_COUNT_EN
    ,
    .retired   (retired)
`endif
  );

  logic [7:0]  irom [4096];
  logic [7:0]  dram [4096];
  logic        ld_en = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [7:0]  ld_val = '0;

  always @(posedge clk) begin
    if (ice) id <= irom[ia];
  end

  always @(posedge clk) begin
    if (drce) drd <= dram[dra];
    if (ld_en)     dram[ld_addr] <= ld_val;
    else if (dwce) dram[dwa] <= dwq;
  end

  int         errors = 0;
  int         checks = 0;
  logic [7:0] sb [$];
  int         wr_cnt, stall_cnt, inwait_cnt;
  bit         hold_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] v);
    ld_addr = a;
    ld_val  = v;
    ld_en   = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic start(input string prog, input logic [7:0] cell0);
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 4096; i++) irom[i] = 8'h00;
    for (int i = 0; i < prog.len(); i++) irom[i] = prog[i];
    poke(12'd0, cell0);
    poke(12'd1, 8'h00);
    poke(12'd2, 8'h00);
    poke(12'hFFF, 8'h00);
    @(negedge clk);
    chk("reset_outputs", {7'd0, ice, drce, dwce, in_ready, out_valid, halted, error, ia, dra},
        32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Watches the DUT each falling edge until halt or budget; output bytes are scored as they appear.
  task automatic run_until_halt(input int max_cyc);
    int          n = 0;
    bit          have_ref = 1'b0;
    logic [7:0]  ref_d = '0;
    logic [11:0] ref_pc = '0;
    wr_cnt = 0; stall_cnt = 0; inwait_cnt = 0; hold_bad = 1'b0;
    while (n < max_cyc) begin
      @(negedge clk);
      n++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("out_unexpected", {31'd0, out_valid}, 32'd0);
        else                chk("out_byte", {24'd0, out_data}, {24'd0, sb.pop_front()});
        have_ref = 1'b0;
      end else if (out_valid) begin
        stall_cnt++;
        if (have_ref && (out_data != ref_d || ia != ref_pc)) hold_bad = 1'b1;
        ref_d = out_data; ref_pc = ia; have_ref = 1'b1;
      end
      if (dwce) wr_cnt++;
      if (in_ready && !in_valid) inwait_cnt++;
      if (halted) break;
    end
    chk("halt_in_time", {31'd0, halted}, 32'd1);
    chk("out_all_seen", sb.size(), 32'd0);
    sb.delete();
  endtask

  task automatic drive_out_stall();
    int k = 0;
    while (!out_valid && k < 200) begin @(negedge clk); k++; end
    repeat (10) @(posedge clk);
    #1 out_ready = 1'b1;
  endtask

  task automatic drive_in_late(input logic [7:0] v);
    int k = 0;
    while (!in_ready && k < 200) begin @(negedge clk); k++; end
    repeat (5) @(posedge clk);
    #1 begin in_valid = 1'b1; in_data = v; end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    string p;

    start("+++.", 8'h00);
    sb.push_back(8'h03);
    run_until_halt(200);
    chk("t1_error", {31'd0, error}, 32'd0);
    chk("t1_writes", wr_cnt, 32'd3);
`ifdef BF_RETIRE_COUNT_EN
    chk("t1_retired", retired, 32'd4);
`endif
    repeat (3) @(negedge clk);
    chk("t1_absorb", {26'd0, ice, drce, dwce, in_ready, out_valid, halted}, 32'd1);

    start("++[>+++<-]>.", 8'h00);
    sb.push_back(8'h06);
    run_until_halt(600);
    chk("t2_error", {31'd0, error}, 32'd0);
    chk("t2_dp", {20'd0, dra}, 32'd1);
    chk("t2_cell0", {24'd0, dram[0]}, 32'd0);

    start("[[+]+].", 8'h00);
    sb.push_back(8'h00);
    run_until_halt(300);
    chk("t3_error", {31'd0, error}, 32'd0);
    chk("t3_writes", wr_cnt, 32'd0);
`ifdef BF_RETIRE_COUNT_EN
    chk("t3_retired", retired, 32'd7);
`endif

    start(",+.", 8'h00);
    sb.push_back(8'h00);
    fork
      run_until_halt(300);
      drive_in_late(8'hFF);
    join
    chk("t4_in_wait", inwait_cnt, 32'd5);
    chk("t4_writes", wr_cnt, 32'd2);
    chk("t4_error", {31'd0, error}, 32'd0);

    start(".", 8'h5A);
    out_ready = 1'b0;
    sb.push_back(8'h5A);
    fork
      run_until_halt(300);
      drive_out_stall();
    join
    chk("t5_stall_cycles", stall_cnt, 32'd10);
    chk("t5_hold_stable", {31'd0, hold_bad}, 32'd0);
    chk("t5_pc_at_halt", {20'd0, ia}, 32'd1);

    start("]", 8'h00);
    run_until_halt(100);
    chk("t6_unmatched_end", {31'd0, error}, 32'd1);

    p = "+";
    for (int i = 0; i < 17; i++) p = {p, "["};
    start(p, 8'h00);
    run_until_halt(400);
    chk("t7_overflow", {31'd0, error}, 32'd1);

    start("<", 8'h00);
    run_until_halt(100);
    chk("t8_error", {31'd0, error}, 32'd0);
    chk("t8_dp_wrap", {20'd0, dra}, 32'hFFF);

    start("[", 8'h00);
    run_until_halt(100);
    chk("t9_halt_in_skip", {31'd0, error}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
